// File: rtl/game_pkg.sv
// Shared types and constants for the pattern generator: note geometry, LFSR
// polynomial, FSM state encoding and the debug bundle exposed by the top.
package game_pkg;

    localparam int          NOTE_W     = 3;
    localparam int          NOTE_COUNT = 8;
    localparam logic [15:0] LFSR_POLY  = 16'hB400;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GEN   = 3'd1,
        WRITE = 3'd2,
        GAP   = 3'd3,
        START = 3'd4,
        PLAY  = 3'd5
    } game_state_t;

    typedef struct packed {
        game_state_t fsm;
        logic [15:0] lfsr;
    } game_debug_t;

    // Right-shifting Galois step; a nonzero state never maps to zero.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/pattern_lfsr.sv
// 16-bit Galois LFSR that steps only when advance is high; loads seed on reset.
module pattern_lfsr
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= seed;
        end else if (advance) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/game_pattern_gen.sv
// Generates an 8-note random pattern on a button press, publishes it, then starts the game core.
// Optional feature macro: GAME_NO_REPEAT_EN (bumps a note that repeats its predecessor).
module game_pattern_gen
    import game_pkg::*;
#(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          START_GAP = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_btn,
    input  logic        game_end,
    output logic [31:0] data_out,
    output logic        write_enable,
    output logic        game_start,
    output logic        busy,
    output logic [7:0]  round_count,
    output game_debug_t debug
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [3:0]  GAP_LAST = 4'(START_GAP - 1);
    localparam logic [2:0]  GEN_LAST = 3'(NOTE_COUNT - 1);

    // Handshake: write_enable and game_start are single-cycle strobes with no
    // back-pressure; data_out is valid while write_enable is high and holds after.

    game_state_t       state, state_next;
    logic              btn_meta, btn_sync, btn_prev, end_prev;
    logic              start_req, end_req;
    logic [2:0]        gen_cnt;
    logic [3:0]        gap_cnt;
    logic [NOTE_W-1:0] notes [NOTE_COUNT];
    logic [NOTE_W-1:0] cand, note;
    logic [31:0]       pattern_word;
    logic [15:0]       lfsr_state;
    logic              lfsr_advance;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_prev <= 1'b0;
            end_prev <= 1'b0;
        end else begin
            btn_meta <= start_btn;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
            end_prev <= game_end;
        end
    end

    assign start_req = btn_sync & ~btn_prev;
    assign end_req   = game_end & ~end_prev;

    // Free-running in IDLE so the pattern depends on when the player presses.
    assign lfsr_advance = (state == IDLE) || (state == GEN);

    pattern_lfsr u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (lfsr_advance),
        .seed    (SEED_EFF),
        .state   (lfsr_state)
    );

    assign cand = lfsr_state[NOTE_W-1:0];

`ifdef GAME_NO_REPEAT_EN
    logic [NOTE_W-1:0] prev_note;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_note <= '0;
        end else if (state == GEN) begin
            prev_note <= note;
        end
    end

    always_comb begin
        note = cand;
        if ((gen_cnt != 3'd0) && (cand == prev_note)) begin
            note = cand + 3'd1;
        end
    end
`else
    always_comb begin
        note = cand;
    end
`endif

    // The last note is merged in combinationally so data_out loads on the GEN->WRITE edge.
    always_comb begin
        pattern_word = '0;
        for (int i = 0; i < NOTE_COUNT; i++) begin
            pattern_word[i*4 +: NOTE_W] = (i == int'(gen_cnt)) ? note : notes[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        write_enable = 1'b0;
        game_start   = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE:  if (start_req) state_next = GEN;
            GEN:   if (gen_cnt == GEN_LAST) state_next = WRITE;
            WRITE: begin
                write_enable = 1'b1;
                state_next   = GAP;
            end
            GAP:   if (gap_cnt == GAP_LAST) state_next = START;
            START: begin
                game_start = 1'b1;
                state_next = PLAY;
            end
            PLAY:  if (end_req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gen_cnt     <= '0;
            gap_cnt     <= '0;
            data_out    <= '0;
            round_count <= '0;
            for (int i = 0; i < NOTE_COUNT; i++) begin
                notes[i] <= '0;
            end
        end else begin
            gen_cnt <= (state == GEN) ? gen_cnt + 3'd1 : 3'd0;
            gap_cnt <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;
            if (state == GEN) begin
                notes[gen_cnt] <= note;
                if (gen_cnt == GEN_LAST) begin
                    data_out <= pattern_word;
                end
            end
            if ((state == PLAY) && end_req && (round_count != 8'hFF)) begin
                round_count <= round_count + 8'd1;
            end
        end
    end

    assign debug = '{fsm: state, lfsr: lfsr_state};

endmodule

// File: tb/tb_game_pattern_gen.sv
// Self-checking bench for game_pattern_gen: random press timing checked against
// a spec-level model of the LFSR note sequence, latency, ignore rules and reset abort.
module tb_game_pattern_gen;
    import game_pkg::*;

    localparam logic [15:0] SEED      = 16'hACE1;
    localparam int          START_GAP = 2;
    // Cycles from the press drive to write_enable: 2 synchronizer stages + 9.
    localparam int          WE_LAT    = 11;
    localparam int          GS_LAT    = WE_LAT + START_GAP + 1;
    localparam int          NONE      = -10;

    logic        clk;
    logic        reset_n;
    logic        start_btn;
    logic        game_end;
    logic [31:0] data_out;
    logic        write_enable;
    logic        game_start;
    logic        busy;
    logic [7:0]  round_count;
    game_debug_t debug;

    int checks;
    int errors;
    int cyc;
    logic [31:0] exp_q[$];

    game_pattern_gen #(.SEED(SEED), .START_GAP(START_GAP)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_btn    (start_btn),
        .game_end     (game_end),
        .data_out     (data_out),
        .write_enable (write_enable),
        .game_start   (game_start),
        .busy         (busy),
        .round_count  (round_count),
        .debug        (debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts rising edges seen with reset released, i.e. LFSR steps while idle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic logic [15:0] model_step(input logic [15:0] s);
        if (s % 2 == 1) return (s / 2) ^ 16'hB400;
        return s / 2;
    endfunction

    function automatic logic [15:0] model_lfsr_at(input int n);
        logic [15:0] s;
        s = (SEED == 16'h0) ? 16'h0001 : SEED;
        for (int i = 0; i < n; i++) s = model_step(s);
        return s;
    endfunction

    // Press driven after edge k: GEN starts after edge k+3, note i uses the k+3+i state.
    function automatic logic [31:0] model_pattern(input int k);
        logic [15:0] s;
        logic [31:0] word;
        int raw, n, prev;
        s = model_lfsr_at(k + 3);
        word = 0;
        prev = -1;
        for (int i = 0; i < 8; i++) begin
            raw = int'(s % 8);
            n = raw;
`ifdef GAME_NO_REPEAT_EN
            if (i > 0 && raw == prev) n = (raw + 1) % 8;
`endif
            word = word | (32'(n) << (4 * i));
            prev = n;
            s = model_step(s);
        end
        return word;
    endfunction

    task automatic apply_reset();
        reset_n = 1'b0;
        start_btn = 1'b0;
        game_end = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Drives one press and observes the following window; comparisons are left to the caller.
    task automatic press_and_watch(input int window, input int press2_at, input int reset_at,
                                   input int end_at, output int k, output int we_cnt,
                                   output int we_pos, output int gs_cnt, output int gs_pos,
                                   output logic [31:0] we_data, output logic reset_ok);
        @(posedge clk);
        #1 start_btn = 1'b1;
        k = cyc;
        we_cnt = 0; gs_cnt = 0; we_pos = -1; gs_pos = -1; we_data = 'x; reset_ok = 1'b1;
        for (int j = 1; j <= window; j++) begin
            @(posedge clk);
            #1;
            if (j == 3) start_btn = 1'b0;
            if (j == press2_at) start_btn = 1'b1;
            if (j == press2_at + 3) start_btn = 1'b0;
            if (j == reset_at) reset_n = 1'b0;
            if (j == reset_at + 2) reset_n = 1'b1;
            if (j == end_at) game_end = 1'b1;
            @(negedge clk);
            if (write_enable) begin we_cnt++; we_pos = j; we_data = data_out; end
            if (game_start) begin gs_cnt++; gs_pos = j; end
            if (j == reset_at)
                reset_ok = (data_out == 0) && !busy && !write_enable && (debug.fsm == IDLE);
        end
    endtask

    task automatic finish_game(input logic [7:0] exp_rc);
        @(posedge clk);
        #1 game_end = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || round_count !== exp_rc) begin
            errors++;
            $display("FAIL end_game busy=%0b rc=%0d want busy=0 rc=%0d", busy, round_count, exp_rc);
        end
        #1 game_end = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if ({data_out, write_enable, game_start, busy, round_count} !== 43'd0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d data=%h we=%b gs=%b busy=%b rc=%0d want all 0",
                         i, data_out, write_enable, game_start, busy, round_count);
            end
        end
    endtask

    task automatic test_single_game();
        int k, wc, wp, gc, gp;
        logic [31:0] wd, exp;
        logic rok;
        for (int it = 0; it < 6; it++) begin
            apply_reset();
            repeat ($urandom_range(0, 40)) @(posedge clk);
            press_and_watch(20, NONE, NONE, NONE, k, wc, wp, gc, gp, wd, rok);
            exp_q.push_back(model_pattern(k));
            exp = exp_q.pop_front();
            checks++;
            if (wc !== 1 || wp !== WE_LAT) begin
                errors++;
                $display("FAIL we_timing it%0d count=%0d pos=%0d want 1 at %0d", it, wc, wp, WE_LAT);
            end
            checks++;
            if (gc !== 1 || gp !== GS_LAT) begin
                errors++;
                $display("FAIL gs_timing it%0d count=%0d pos=%0d want 1 at %0d", it, gc, gp, GS_LAT);
            end
            checks++;
            if (wd !== exp) begin
                errors++;
                $display("FAIL pattern it%0d k=%0d got %h want %h", it, k, wd, exp);
            end
            checks++;
            if ((wd & 32'h8888_8888) !== 32'd0) begin
                errors++;
                $display("FAIL pad_bits it%0d got %h want pad bits 0", it, wd);
            end
            finish_game(8'd1);
            checks++;
            if (data_out !== exp) begin
                errors++;
                $display("FAIL data_hold it%0d got %h want %h", it, data_out, exp);
            end
        end
    endtask

    task automatic test_ignore_start();
        int k, wc, wp, gc, gp, extra;
        logic [31:0] wd;
        logic rok;
        apply_reset();
        press_and_watch(24, 12, NONE, NONE, k, wc, wp, gc, gp, wd, rok);
        checks++;
        if (wc !== 1 || gc !== 1) begin
            errors++;
            $display("FAIL gap_press we=%0d gs=%0d want 1 and 1", wc, gc);
        end
        extra = 0;
        @(posedge clk);
        #1 start_btn = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (write_enable || game_start || !busy) extra++;
            if (j == 4) start_btn = 1'b0;
        end
        checks++;
        if (extra !== 0 || round_count !== 8'd0) begin
            errors++;
            $display("FAIL play_press events=%0d rc=%0d want 0 and 0", extra, round_count);
        end
        finish_game(8'd1);
    endtask

    task automatic test_reset_abort();
        int k, wc, wp, gc, gp;
        logic [31:0] wd;
        logic rok;
        apply_reset();
        press_and_watch(20, NONE, NONE, NONE, k, wc, wp, gc, gp, wd, rok);
        finish_game(8'd1);
        // Reset during GEN cycle 4.
        press_and_watch(24, NONE, 7, NONE, k, wc, wp, gc, gp, wd, rok);
        checks++;
        if (!rok || wc !== 0 || gc !== 0 || data_out !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_gen rst_ok=%0b we=%0d gs=%0d data=%h busy=%b want 1,0,0,0,0",
                     rok, wc, gc, data_out, busy);
        end
        // Reset during GAP: the write already happened, the start must not.
        press_and_watch(24, NONE, 12, NONE, k, wc, wp, gc, gp, wd, rok);
        checks++;
        if (!rok || wc !== 1 || gc !== 0 || data_out !== 32'd0 || round_count !== 8'd0) begin
            errors++;
            $display("FAIL abort_gap rst_ok=%0b we=%0d gs=%0d data=%h rc=%0d want 1,1,0,0,0",
                     rok, wc, gc, data_out, round_count);
        end
    endtask

    task automatic test_no_repeat();
        int k, wc, wp, gc, gp, base, target, raw, exp1;
        logic [31:0] wd;
        logic rok, found;
        logic [15:0] s, ns;
        apply_reset();
        base = cyc + 2;
        s = model_lfsr_at(base + 3);
        found = 1'b0;
        target = 0;
        for (int c = base; c < base + 2000 && !found; c++) begin
            ns = model_step(s);
            if (s % 8 == ns % 8) begin found = 1'b1; target = c; end
            s = ns;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL repeat_search found=0 want 1");
        end else begin
            while (cyc < target - 1) begin
                @(posedge clk);
                #1;
            end
            press_and_watch(16, NONE, NONE, NONE, k, wc, wp, gc, gp, wd, rok);
            s = model_lfsr_at(target + 3);
            raw = int'(s % 8);
`ifdef GAME_NO_REPEAT_EN
            exp1 = (raw + 1) % 8;
`else
            exp1 = raw;
`endif
            checks++;
            if (k !== target || int'(wd[3:0]) !== raw || int'(wd[7:4]) !== exp1) begin
                errors++;
                $display("FAIL repeat_notes k=%0d n0=%0d n1=%0d want k=%0d n0=%0d n1=%0d",
                         k, wd[3:0], wd[7:4], target, raw, exp1);
            end
            checks++;
            if (wd !== model_pattern(k)) begin
                errors++;
                $display("FAIL repeat_pattern got %h want %h", wd, model_pattern(k));
            end
        end
    endtask

    task automatic test_saturation();
        int waited;
        logic seen;
        apply_reset();
        for (int g = 1; g <= 256; g++) begin
            @(posedge clk);
            #1 start_btn = 1'b1;
            seen = 1'b0;
            waited = 0;
            while (!seen && waited < 40) begin
                @(negedge clk);
                waited++;
                if (game_start) seen = 1'b1;
                if (waited == 3) start_btn = 1'b0;
            end
            start_btn = 1'b0;
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL game_start_timeout game=%0d waited=%0d want pulse", g, waited);
            end
            @(posedge clk);
            #1 game_end = 1'b1;
            repeat (2) @(posedge clk);
            #1 game_end = 1'b0;
            @(negedge clk);
            if (g == 1 || g == 255 || g == 256) begin
                checks++;
                if (round_count !== ((g > 255) ? 8'd255 : 8'(g)) || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL round_count game=%0d got %0d busy=%b want %0d busy=0",
                             g, round_count, busy, (g > 255) ? 255 : g);
                end
            end
        end
    endtask

    task automatic test_end_held();
        int k, wc, wp, gc, gp, exits;
        logic [31:0] wd;
        logic rok;
        apply_reset();
        press_and_watch(20, NONE, NONE, 5, k, wc, wp, gc, gp, wd, rok);
        exits = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (!busy || debug.fsm !== PLAY) exits++;
        end
        #1 game_end = 1'b0;
        repeat (2) @(negedge clk);
        if (!busy) exits++;
        checks++;
        if (gc !== 1 || exits !== 0 || round_count !== 8'd0) begin
            errors++;
            $display("FAIL end_held gs=%0d early_exits=%0d rc=%0d want 1,0,0", gc, exits, round_count);
        end
        finish_game(8'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        start_btn = 1'b0;
        game_end = 1'b0;
        test_reset();
        test_single_game();
        test_ignore_start();
        test_reset_abort();
        test_no_repeat();
        test_end_held();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
